spi_slave: RTL and testbench
============================

# spi_slave

Byte-oriented SPI slave: the far end of the link driven by `SPI_Master`. Runs entirely in the local `i_Clk` domain. SPI clock, MOSI and chip-select are oversampled through synchronizers. Received bytes are presented with a 1-cycle valid pulse, and a single-entry holding register supplies the byte shifted out on MISO, MSB first. Supports all four SPI modes, selected by parameter.

## Interface
- `SPI_MODE`, default 0: 0..3. CPOL = `SPI_MODE[1]`, CPHA = `SPI_MODE[0]`. Must match the master.
- `i_Clk`, input, 1: system clock. Only clock in the block.
- `i_Rst_L`, input, 1: reset, asynchronous, active-low.
- `o_RX_DV`, output, 1: 1-cycle pulse when `o_RX_Byte` is updated.
- `o_RX_Byte`, output, 8: last complete byte received on MOSI.
- `i_TX_DV`, input, 1: load `i_TX_Byte` into the holding register.
- `i_TX_Byte`, input, 8: next byte for MISO.
- `o_TX_Ready`, output, 1: high when the holding register is empty.
- `i_SPI_Clk`, input, 1: SCK from master, asynchronous.
- `i_SPI_MOSI`, input, 1: master-out data.
- `o_SPI_MISO`, output, 1: slave-out data.
- `o_SPI_MISO_En`, output, 1: MISO output enable, for an external tri-state.
- `i_SPI_CS_n`, input, 1: chip select, active-low.

## Operation
- **Input synchronization.** `i_SPI_Clk`, `i_SPI_MOSI` and `i_SPI_CS_n` each pass through a 2-flop synchronizer. A third SCK flop provides edge detection.
- **Edge roles.** Leading edge = first edge away from CPOL idle level; trailing edge = the return.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
  - Edges seen while synced CS_n is high are ignored.
- **States: IDLE** (CS_n high; bit count 0; `o_SPI_MISO_En`=0).
  - Synced CS_n falling → ACTIVE.
  - If CPHA=0, a byte-start event occurs at the same time.
- **States: ACTIVE** (`o_SPI_MISO_En`=1).
  - Each sample edge shifts MOSI into the RX shift register, LSB side, so MSB is received first. The 3-bit bit count then increments.
  - On the 8th sample edge the count wraps to 0: `o_RX_Byte` ← assembled byte, `o_RX_DV`=1 for one cycle.
  - Synced CS_n rising → IDLE. A partial byte is discarded, with no `o_RX_DV`.
- **Byte-start event.** TX shift register ← holding register if full, else 8'hFF. The holding register is marked empty. `o_SPI_MISO` ← bit 7.
  - CPHA=0: on CS_n falling, and on each trailing edge that follows a wrapping sample edge (CS still low).
  - CPHA=1: on the leading edge while bit count = 0.
  - All other shift edges drive the next lower TX bit.
- **Holding register.** `i_TX_DV` while full overwrites the held byte. `i_TX_DV` in the same cycle as a byte-start event:
  - The old content, or 8'hFF if empty, is consumed by the byte start.
  - The new byte is held, and the register stays full.
- **Back-to-back bytes.** Multiple bytes per CS assertion are allowed; the bit count runs continuously.

## Timing
- **Reset values** (immediate on `i_Rst_L` low, regardless of state):
  - `o_RX_DV`=0, `o_RX_Byte`=8'h00, `o_TX_Ready`=1.
  - `o_SPI_MISO`=0, `o_SPI_MISO_En`=0.
  - Synchronizer SCK flops reset to 0; all CS_n synchronizer flops reset to 1 (deasserted). The edge detector must not see a spurious edge at reset release.
  - State IDLE, bit count 0, holding register empty.
- **SCK constraint.** Each SCK half-period must be at least 4 `i_Clk` cycles. CS_n falling must lead the first SCK edge by at least 4 `i_Clk` cycles.
- **Receive latency.** `o_RX_DV` asserts 3 `i_Clk` cycles after the raw 8th sample edge: 2 sync + 1 register.
- **Transmit latency.** `o_SPI_MISO` changes 3 `i_Clk` cycles after the raw shift edge or CS_n fall. This is within the master's half-period margin.
- **`o_TX_Ready`.**
  - Falls the cycle after `i_TX_DV`.
  - Rises the cycle after the byte-start event that consumes the held byte, unless `i_TX_DV` coincides with that event.
- **`o_SPI_MISO_En`.** Follows synced CS_n, registered.

## Test plan
1. **Mode 3 single byte.** SPI_MODE=3, half-period 4 clks. Load 8'h5A; master sends 8'hC1. Required: one `o_RX_DV` pulse with `o_RX_Byte`=8'hC1; master captures 8'h5A; `o_TX_Ready` 0 then 1.
2. **Two bytes in one CS assertion.** Master sends 8'hBE then 8'hEF with CS held low. Slave loads 8'h12, then 8'h34 once `o_TX_Ready` rises. Required: exactly two `o_RX_DV` pulses (BE, EF); master receives 12, 34.
3. **Empty holding register.** No `i_TX_DV`; master sends 8'h00. Required: master receives 8'hFF; `o_RX_Byte`=8'h00.
4. **CS abort.** CS_n raised after 5 bits, then a full 8'hA5 transfer. Required: no `o_RX_DV` for the aborted byte; next pulse carries 8'hA5.
5. **Mode 0 and mode 1.** Repeat scenario 1 with SPI_MODE=0 and with SPI_MODE=1. Required: identical results.
6. **Reset mid-byte.** Assert `i_Rst_L` low after 3 bits. Required: all outputs at reset values in the same cycle; a subsequent 8'h3C transfer is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave running entirely in the i_Clk domain.
// SCK/MOSI/CS_n are oversampled; a single-entry holding register feeds MISO.
module spi_slave #(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En,
  input  logic       i_SPI_CS_n
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        sck_s1;
  logic        sck_s2;
  logic        sck_s3;
  logic        mosi_s1;
  logic        mosi_s2;
  logic        cs_s1;
  logic        cs_s2;

  logic        sck_rise;
  logic        sck_fall;
  logic        lead_edge;
  logic        trail_edge;
  logic        sample_evt;
  logic        shift_evt;
  logic        byte_start;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [6:0]  tx_shift;
  logic        hold_full;
  logic [7:0]  hold_byte;
  logic [7:0]  tx_src;

  // CS_n flops reset deasserted so reset release never looks like a select
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
    end else begin
      sck_s1  <= i_SPI_Clk;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= i_SPI_MOSI;
      mosi_s2 <= mosi_s1;
      cs_s1   <= i_SPI_CS_n;
      cs_s2   <= cs_s1;
    end
  end

  assign sck_rise   = sck_s2 & ~sck_s3;
  assign sck_fall   = ~sck_s2 & sck_s3;
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;
  assign tx_src     = hold_full ? hold_byte : 8'hFF;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Edges are only honoured while ACTIVE with CS_n still low; a shift edge
  // at bit count 0 is always the start of a new byte in either phase.
  always_comb begin
    state_d    = state_q;
    sample_evt = 1'b0;
    shift_evt  = 1'b0;
    byte_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s2) begin
          state_d    = ST_ACTIVE;
          byte_start = !CPHA;
        end
      end
      ST_ACTIVE: begin
        if (cs_s2) begin
          state_d = ST_IDLE;
        end else begin
          sample_evt = CPHA ? trail_edge : lead_edge;
          shift_evt  = CPHA ? lead_edge : trail_edge;
          byte_start = shift_evt && (bit_cnt == 3'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_SPI_MISO_En = (state_q == ST_ACTIVE);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      o_RX_Byte <= 8'h00;
      o_RX_DV   <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (state_d == ST_IDLE) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
      end else if (sample_evt) begin
        rx_shift <= {rx_shift[5:0], mosi_s2};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_RX_Byte <= {rx_shift, mosi_s2};
          o_RX_DV   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_shift   <= 7'd0;
      o_SPI_MISO <= 1'b0;
    end else if (byte_start) begin
      tx_shift   <= tx_src[6:0];
      o_SPI_MISO <= tx_src[7];
    end else if (shift_evt) begin
      tx_shift   <= {tx_shift[5:0], 1'b0};
      o_SPI_MISO <= tx_shift[6];
    end
  end

  // A load coinciding with a byte start wins: the old content is consumed
  // by the byte start and the new byte stays held.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_full <= 1'b0;
      hold_byte <= 8'h00;
    end else if (i_TX_DV) begin
      hold_full <= 1'b1;
      hold_byte <= i_TX_Byte;
    end else if (byte_start) begin
      hold_full <= 1'b0;
    end
  end

  assign o_TX_Ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: three instances (modes 3, 0, 1) share SCK/MOSI,
// each has its own CS_n; received bytes are scoreboarded against exp_q.
module tb_spi_slave;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck;
  logic       mosi;
  logic [2:0] cs_n;
  logic [2:0] tx_dv;
  logic [7:0] tx_byte [3];
  logic [2:0] rx_dv;
  logic [7:0] rx_byte [3];
  logic [2:0] tx_ready;
  logic [2:0] miso;
  logic [2:0] miso_en;

  int         sel = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  spi_slave #(.SPI_MODE(3)) u_m3 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
    .i_TX_DV(tx_dv[0]), .i_TX_Byte(tx_byte[0]), .o_TX_Ready(tx_ready[0]),
    .i_SPI_Clk(sck), .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[0]),
    .o_SPI_MISO_En(miso_en[0]), .i_SPI_CS_n(cs_n[0])
  );

  spi_slave #(.SPI_MODE(0)) u_m0 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
    .i_TX_DV(tx_dv[1]), .i_TX_Byte(tx_byte[1]), .o_TX_Ready(tx_ready[1]),
    .i_SPI_Clk(sck), .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[1]),
    .o_SPI_MISO_En(miso_en[1]), .i_SPI_CS_n(cs_n[1])
  );

  spi_slave #(.SPI_MODE(1)) u_m1 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .o_RX_DV(rx_dv[2]), .o_RX_Byte(rx_byte[2]),
    .i_TX_DV(tx_dv[2]), .i_TX_Byte(tx_byte[2]), .o_TX_Ready(tx_ready[2]),
    .i_SPI_Clk(sck), .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[2]),
    .o_SPI_MISO_En(miso_en[2]), .i_SPI_CS_n(cs_n[2])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int mode_of(input int idx);
    case (idx)
      0:       return 3;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  // scoreboard: every o_RX_DV pulse must belong to the selected instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_dv[k] === 1'b1) begin
        checks++;
        assert (k == sel && exp_q.size() != 0) else begin
          errors++;
          $error("FAIL rx_unexpected: observed pulse inst %0d byte %h expected no pulse", k, rx_byte[k]);
        end
        if (k == sel && exp_q.size() != 0) check("rx_byte", rx_byte[k], exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic select_inst(input int idx);
    sel = idx;
    sck = (mode_of(idx) >= 2);
    wait_clks(HALF);
  endtask

  task automatic load_tx(input int idx, input logic [7:0] b);
    tx_byte[idx] = b;
    tx_dv[idx]   = 1'b1;
    @(negedge clk);
    tx_dv[idx]   = 1'b0;
    check("tx_ready_after_load", 8'(tx_ready[idx]), 8'h00);
  endtask

  task automatic cs_assert(input int idx);
    cs_n[idx] = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_release(input int idx);
    wait_clks(HALF);
    cs_n[idx] = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic spi_bits(input int mode, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic       cpol;
    logic       cpha;
    logic [7:0] sh;
    cpol = (mode >= 2);
    cpha = (mode % 2 == 1);
    sh   = tx;
    rx   = 8'h00;
    if (!cpha) begin
      mosi = sh[7];
      wait_clks(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      sck = ~cpol;
      if (cpha) mosi = sh[7];
      else      rx = {rx[6:0], miso[sel]};
      wait_clks(HALF);
      sck = cpol;
      if (cpha) rx = {rx[6:0], miso[sel]};
      else      mosi = sh[6];
      wait_clks(HALF);
      sh = {sh[6:0], 1'b0};
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_miso);
    logic [7:0] got;
    exp_q.push_back(tx);
    spi_bits(mode_of(sel), tx, 8, got);
    check("master_rx", got, exp_miso);
  endtask

  task automatic wait_ready(input int idx);
    for (int n = 0; n < 20 && tx_ready[idx] !== 1'b1; n++) @(negedge clk);
    check("tx_ready_rise", 8'(tx_ready[idx]), 8'h01);
  endtask

  task automatic single_byte(input int idx);
    select_inst(idx);
    load_tx(idx, 8'h5A);
    cs_assert(idx);
    check("miso_en_active", 8'(miso_en[idx]), 8'h01);
    xfer(8'hC1, 8'h5A);
    cs_release(idx);
    check("tx_ready_done", 8'(tx_ready[idx]), 8'h01);
    check("miso_en_idle", 8'(miso_en[idx]), 8'h00);
    check("rx_pending", 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] junk;
    rst_n      = 1'b0;
    cs_n       = 3'b111;
    tx_dv      = 3'b000;
    tx_byte[0] = 8'h00;
    tx_byte[1] = 8'h00;
    tx_byte[2] = 8'h00;
    sck        = 1'b1;
    mosi       = 1'b0;
    wait_clks(3);
    check("reset_rx_dv", 8'(rx_dv[0]), 8'h00);
    check("reset_rx_byte", rx_byte[0], 8'h00);
    check("reset_tx_ready", 8'(tx_ready[0]), 8'h01);
    check("reset_miso", 8'(miso[0]), 8'h00);
    check("reset_miso_en", 8'(miso_en[0]), 8'h00);
    rst_n = 1'b1;
    wait_clks(HALF);

    // mode 3 single byte
    single_byte(0);

    // two bytes in one CS assertion
    load_tx(0, 8'h12);
    cs_assert(0);
    xfer(8'hBE, 8'h12);
    wait_ready(0);
    load_tx(0, 8'h34);
    xfer(8'hEF, 8'h34);
    cs_release(0);
    check("rx_pending_two", 8'(exp_q.size()), 8'h00);
    check("rx_byte_two", rx_byte[0], 8'hEF);

    // empty holding register
    cs_assert(0);
    xfer(8'h00, 8'hFF);
    cs_release(0);
    check("rx_byte_zero", rx_byte[0], 8'h00);

    // CS abort after 5 bits, then a full byte
    cs_assert(0);
    spi_bits(3, 8'hFF, 5, junk);
    cs_release(0);
    check("abort_rx_byte", rx_byte[0], 8'h00);
    cs_assert(0);
    xfer(8'hA5, 8'hFF);
    cs_release(0);
    check("rx_pending_abort", 8'(exp_q.size()), 8'h00);

    // modes 0 and 1
    single_byte(1);
    single_byte(2);

    // reset mid-byte
    select_inst(0);
    cs_assert(0);
    spi_bits(3, 8'h00, 3, junk);
    load_tx(0, 8'h99);
    check("pre_reset_miso_en", 8'(miso_en[0]), 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rx_dv", 8'(rx_dv[0]), 8'h00);
    check("midrst_rx_byte", rx_byte[0], 8'h00);
    check("midrst_tx_ready", 8'(tx_ready[0]), 8'h01);
    check("midrst_miso", 8'(miso[0]), 8'h00);
    check("midrst_miso_en", 8'(miso_en[0]), 8'h00);
    @(negedge clk);
    cs_n[0] = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(HALF);
    cs_assert(0);
    xfer(8'h3C, 8'hFF);
    cs_release(0);
    check("post_reset_rx_byte", rx_byte[0], 8'h3C);
    check("rx_pending_final", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
